// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
// Byte-lane stores and sign/zero-extended loads against an internal word array.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem [DEPTH];

  logic        accept, commit, err, wr_en;
  logic        cur_we, cur_uns;
  logic [31:0] cur_addr, cur_wdata, word, load;
  logic [1:0]  cur_size;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [ADDR_WIDTH-3:0] idx;

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait states the commit edge is the accept edge, so use the live request.
  assign cur_we    = (state_q == IDLE) ? req_we       : we_q;
  assign cur_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr     : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
  assign cur_size  = (state_q == IDLE) ? req_size     : size_q;

  assign commit = ((state_q == WAIT) && (cnt_q == 4'd1)) || (accept && (WAIT_STATES == 0));

  assign err = (cur_size == 2'b11)
             || ((cur_size == 2'b01) && cur_addr[0])
             || ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00))
             || (cur_addr[31:ADDR_WIDTH] != '0);

  assign idx   = cur_addr[ADDR_WIDTH-1:2];
  assign word  = mem[idx];
  assign wr_en = commit && cur_we && !err;

  always_comb begin
    lane_byte = word[7:0];
    case (cur_addr[1:0])
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      2'd3:    lane_byte = word[31:24];
      default: lane_byte = word[7:0];
    endcase
    lane_half = cur_addr[1] ? word[31:16] : word[15:0];
    case (cur_size)
      2'b00:   load = cur_uns ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load = cur_uns ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load = word;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    wd = cur_wdata;
    case (cur_size)
      2'b00: begin
        be = 4'b0001 << cur_addr[1:0];
        wd = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign rdata_d = (commit && !cur_we && !err) ? load : 32'b0;
  assign err_d   = commit && err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = WS;
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      size_q  <= 2'b00;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && be[b]) mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
// Three instances cover WAIT_STATES of 2, 0 and 3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v2 = 1'b0, v0 = 1'b0, v3 = 1'b0;
  logic        we = 1'b0, uns = 1'b0;
  logic [31:0] addr = 32'b0, wdata = 32'b0;
  logic [1:0]  size = 2'b10;

  logic        rdy2, rv2, er2, rdy0, rv0, er0, rdy3, rv3, er3;
  logic [31:0] rd2, rd0, rd3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb2[$], sb0[$], sb3[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   acc0 = 0, last0 = -1, low3 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_size(size), .req_unsigned(uns),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(er2));

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_size(size), .req_unsigned(uns),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0));

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_size(size), .req_unsigned(uns),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3));

  always @(negedge clk) begin
    exp_t e;
    if (rv2 === 1'b1) begin
      total++;
      if (sb2.size() == 0) begin
        bad++;
        $display("FAIL rsp2_unexpected cyc=%0d got valid=1 want no response", cyc);
      end else begin
        e = sb2.pop_front();
        if (rd2 !== e.rdata || er2 !== e.err || cyc != e.at) begin
          bad++;
          $display("FAIL rsp2 got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                   rd2, er2, cyc, e.rdata, e.err, e.at);
        end
      end
    end else if (!rst) begin
      total++;
      if (rd2 !== 32'b0 || er2 !== 1'b0) begin
        bad++;
        $display("FAIL idle2 cyc=%0d got rdata=%h err=%b want 0/0", cyc, rd2, er2);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (v0 && rdy0 === 1'b1) begin
      e.rdata = 32'b0; e.err = 1'b0; e.at = cyc + 1;
      sb0.push_back(e);
      acc0++;
      if (last0 >= 0) begin
        total++;
        if (cyc - last0 != 2) begin
          bad++;
          $display("FAIL spacing0 got %0d want 2", cyc - last0);
        end
      end
      last0 = cyc;
    end
    if (rv0 === 1'b1) begin
      total++;
      if (sb0.size() == 0) begin
        bad++;
        $display("FAIL rsp0_unexpected cyc=%0d", cyc);
      end else begin
        e = sb0.pop_front();
        if (rd0 !== e.rdata || er0 !== e.err || cyc != e.at) begin
          bad++;
          $display("FAIL rsp0 got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                   rd0, er0, cyc, e.rdata, e.err, e.at);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdy3 === 1'b0) low3++;
    if (v3 && rdy3 === 1'b1) begin
      e.rdata = 32'b0; e.err = 1'b0; e.at = cyc + 4;
      sb3.push_back(e);
    end
    if (rv3 === 1'b1) begin
      total++;
      if (sb3.size() == 0) begin
        bad++;
        $display("FAIL rsp3_unexpected cyc=%0d", cyc);
      end else begin
        e = sb3.pop_front();
        if (rd3 !== e.rdata || er3 !== e.err || cyc != e.at) begin
          bad++;
          $display("FAIL rsp3 got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                   rd3, er3, cyc, e.rdata, e.err, e.at);
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (rdy2 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL ready_timeout got ready=%b want 1", rdy2);
      return;
    end
    we = w; addr = a; wdata = d; size = sz; uns = u; v2 = 1'b1;
    e.rdata = exp_rdata; e.err = exp_err; e.at = cyc + 3;
    sb2.push_back(e);
    @(posedge clk);
    #1 v2 = 1'b0;
    n = 0;
    while (sb2.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb2.size() != 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout got pending=%0d want 0", sb2.size());
      sb2.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (rdy2 !== 1'b1 || rv2 !== 1'b0 || rd2 !== 32'b0 || er2 !== 1'b0) begin
      bad++;
      $display("FAIL reset got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
               rdy2, rv2, rd2, er2);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte();
    do_req(1'b1, 32'h13, 32'h80, 2'b00, 1'b0, 32'h0,        1'b0);
    do_req(1'b0, 32'h13, 32'h0,  2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 32'h13, 32'h0,  2'b00, 1'b1, 32'h00000080, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,  2'b10, 1'b1, 32'h80ADBEEF, 1'b0);
  endtask

  task automatic test_half();
    do_req(1'b0, 32'h12, 32'h0,    2'b01, 1'b0, 32'hFFFF80AD, 1'b0);
    do_req(1'b0, 32'h12, 32'h0,    2'b01, 1'b1, 32'h000080AD, 1'b0);
    do_req(1'b1, 32'h10, 32'h1234, 2'b01, 1'b0, 32'h0,        1'b0);
    do_req(1'b0, 32'h10, 32'h0,    2'b10, 1'b0, 32'h80AD1234, 1'b0);
  endtask

  task automatic test_errors();
    do_req(1'b0, 32'h12,   32'h0,    2'b10, 1'b0, 32'h0, 1'b1);
    do_req(1'b1, 32'h11,   32'h5555, 2'b01, 1'b0, 32'h0, 1'b1);
    do_req(1'b0, 32'h10,   32'h0,    2'b10, 1'b0, 32'h80AD1234, 1'b0);
    do_req(1'b0, 32'h1000, 32'h0,    2'b10, 1'b0, 32'h0, 1'b1);
    do_req(1'b0, 32'h10,   32'h0,    2'b11, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    we = 1'b1; addr = 32'h0; wdata = 32'h0; size = 2'b10; uns = 1'b0;
    acc0 = 0; last0 = -1; v0 = 1'b1;
    repeat (8) @(posedge clk);
    #1 v0 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (acc0 != 4 || sb0.size() != 0) begin
      bad++;
      $display("FAIL accepts0 got accepts=%0d pending=%0d want 4/0", acc0, sb0.size());
    end
  endtask

  task automatic test_wait3();
    @(posedge clk);
    #1;
    we = 1'b1; addr = 32'h4; wdata = 32'h0; size = 2'b10; uns = 1'b0;
    low3 = 0; v3 = 1'b1;
    @(posedge clk);
    #1 v3 = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (low3 != 4 || sb3.size() != 0) begin
      bad++;
      $display("FAIL ready3_low got cycles=%0d pending=%0d want 4/0", low3, sb3.size());
    end
  endtask

  task automatic test_reset_mid();
    do_req(1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'hAAAAAAAA; size = 2'b10; uns = 1'b0; v2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    total++;
    if (rdy2 !== 1'b0) begin
      bad++;
      $display("FAIL busy_before_reset got ready=%b want 0", rdy2);
    end
    rst = 1'b1;
    #1;
    total++;
    if (rdy2 !== 1'b1 || rv2 !== 1'b0 || rd2 !== 32'b0 || er2 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
               rdy2, rv2, rd2, er2);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_wait3();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
